axil_master_bridge: RTL

AXIL_MASTER_BRIDGE -- requirements
Module: axil_master_bridge

---
 rtl/axil_pkg.sv | 35 +++
 rtl/axil_master_bridge.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg
// Shared definitions for the AXI4-Lite bridge and the UART slave it talks to:
//   - state_t        : bridge FSM states
//   - OKAY/SLVERR/DECERR : AXI response codes
//   - UART_REG_*     : register byte offsets of the UART slave
//   - in_wait_state  : true in the states where the B/R timeout runs
// ---------------------------------------------------------------------------
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5,
    DRAIN   = 3'd6
  } state_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [31:0] UART_REG_TXDATA  = 32'h0000_0000;
  localparam logic [31:0] UART_REG_RXDATA  = 32'h0000_0004;
  localparam logic [31:0] UART_REG_STATUS  = 32'h0000_0008;
  localparam logic [31:0] UART_REG_CTRL    = 32'h0000_000C;
  localparam logic [31:0] UART_REG_BAUDDIV = 32'h0000_0010;

  function automatic logic in_wait_state(input state_t s);
    return (s == WR_RESP) || (s == RD_RESP);
  endfunction

endpackage

// File: rtl/axil_master_bridge.sv
// ---------------------------------------------------------------------------
// axil_master_bridge
// Turns single CPU-side commands into AXI4-Lite master transactions, one at a
// time, and returns one response per command. A B/R beat that does not arrive
// within TIMEOUT_CYCLES produces a SLVERR response flagged rsp_timeout; the
// late beat is then sunk in DRAIN before the next command is accepted.
//
// Ports
//   ACLK, ARESETN                 clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_write,   command port (addr, write data, byte strobe)
//   cmd_addr, cmd_wdata, cmd_wstrb
//   rsp_valid/ready, rsp_rdata,   response port (read data, AXI resp code,
//   rsp_resp, rsp_timeout         timeout flag)
//   AW*, W*, B*, AR*, R*          AXI4-Lite master channels
// ---------------------------------------------------------------------------
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY,
  output logic [31:0] ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  state_t      state_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  wstrb_reg;
  logic        aw_done_reg;
  logic        w_done_reg;
  logic [15:0] wait_cnt_reg;
  logic        drain_reg;
  logic [31:0] rsp_rdata_reg;
  logic [1:0]  rsp_resp_reg;
  logic        rsp_timeout_reg;

  logic cmd_fire;
  logic aw_ok;
  logic w_ok;
  logic b_fire;
  logic r_fire;
  logic tmo_fire;
  logic drain_fire;

  assign cmd_fire   = cmd_valid && (state_reg == IDLE);
  // A channel counts as done if it handshook earlier or is handshaking now,
  // so AW and W may complete in either order or together.
  assign aw_ok      = aw_done_reg || AWREADY;
  assign w_ok       = w_done_reg  || WREADY;
  assign b_fire     = (state_reg == WR_RESP) && BVALID;
  assign r_fire     = (state_reg == RD_RESP) && RVALID;
  // The real beat has priority over an expiry on the same cycle.
  assign tmo_fire   = in_wait_state(state_reg) && !b_fire && !r_fire &&
                      (wait_cnt_reg == WAIT_LAST);
  assign drain_fire = (state_reg == DRAIN) && (BVALID || RVALID);

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cmd_valid) state_next = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (aw_ok && w_ok) state_next = WR_RESP;
      WR_RESP: if (b_fire || tmo_fire) state_next = RSP;
      RD_REQ:  if (ARREADY) state_next = RD_RESP;
      RD_RESP: if (r_fire || tmo_fire) state_next = RSP;
      RSP:     if (rsp_ready) state_next = drain_reg ? DRAIN : IDLE;
      DRAIN:   if (drain_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs, decoded from state
  always_comb begin
    cmd_ready = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    rsp_valid = 1'b0;
    case (state_reg)
      IDLE:    cmd_ready = 1'b1;
      WR_REQ: begin
        AWVALID = !aw_done_reg;
        WVALID  = !w_done_reg;
      end
      WR_RESP: BREADY    = 1'b1;
      RD_REQ:  ARVALID   = 1'b1;
      RD_RESP: RREADY    = 1'b1;
      RSP:     rsp_valid = 1'b1;
      DRAIN: begin
        BREADY = 1'b1;
        RREADY = 1'b1;
      end
      default: ;
    endcase
  end

  // Command capture, handshake tracking, wait counter and response capture
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      addr_reg        <= '0;
      wdata_reg       <= '0;
      wstrb_reg       <= '0;
      aw_done_reg     <= 1'b0;
      w_done_reg      <= 1'b0;
      wait_cnt_reg    <= '0;
      drain_reg       <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_resp_reg    <= OKAY;
      rsp_timeout_reg <= 1'b0;
    end else begin
      if (cmd_fire) begin
        addr_reg  <= cmd_addr;
        wdata_reg <= cmd_wdata;
        wstrb_reg <= cmd_wstrb;
      end

      if (state_reg == WR_REQ) begin
        if (AWREADY) aw_done_reg <= 1'b1;
        if (WREADY)  w_done_reg  <= 1'b1;
      end else begin
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end

      // Held at zero outside the wait states, so it starts from 0 on entry.
      if (in_wait_state(state_reg)) begin
        wait_cnt_reg <= wait_cnt_reg + 16'd1;
      end else begin
        wait_cnt_reg <= '0;
      end

      if (b_fire) begin
        rsp_resp_reg    <= BRESP;
        rsp_rdata_reg   <= '0;
        rsp_timeout_reg <= 1'b0;
      end else if (r_fire) begin
        rsp_resp_reg    <= RRESP;
        rsp_rdata_reg   <= RDATA;
        rsp_timeout_reg <= 1'b0;
      end else if (tmo_fire) begin
        rsp_resp_reg    <= SLVERR;
        rsp_rdata_reg   <= '0;
        rsp_timeout_reg <= 1'b1;
        drain_reg       <= 1'b1;
      end

      if (drain_fire) drain_reg <= 1'b0;
    end
  end

  assign AWADDR      = addr_reg;
  assign ARADDR      = addr_reg;
  assign WDATA       = wdata_reg;
  assign WSTRB       = wstrb_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_resp    = rsp_resp_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule
